// File: rtl/trace_pkg.sv
// trace_pkg: shared state encoding, width constants and width-stepping helper
package trace_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RESET  = 3'd1,
    HUNT   = 3'd2,
    LOCKED = 3'd3,
    NEXT   = 3'd4
  } state_t;
  localparam logic [2:0] W1 = 3'd1;
  localparam logic [2:0] W2 = 3'd2;
  localparam logic [2:0] W4 = 3'd4;
  function automatic logic [2:0] next_width(input logic [2:0] w);
    return w == W4 ? W2 : w == W2 ? W1 : W4;
  endfunction
endpackage

// File: rtl/trace_sat_counter.sv
// trace_sat_counter: W-bit saturating incrementer; ports clk, rst (sync, active-low clear), inc_i, cnt_o
module trace_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  assign cnt_d = inc_i && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/trace_if_ctrl.sv
// trace_if_ctrl: trace front-end sequencer hunting a bus width (4/2/1 or fixed) until sync locks
// Ports: clk; rst (sync, active-low); enable; cfgWidth/cfgStb host config; sync from input stage;
// width/ifRst to input stage; locked/state status; lossCnt/huntFailCnt stats.
// Stats counters exist only with TRACE_IF_CTRL_STATS_EN defined; otherwise they read 0.
module trace_if_ctrl
  import trace_pkg::*;
#(
  parameter int RST_CYCLES  = 16,
  parameter int HUNT_CYCLES = 2_000_000,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [2:0]       cfgWidth,
  input  logic             cfgStb,
  input  logic             sync,
  output logic [2:0]       width,
  output logic             ifRst,
  output logic             locked,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] lossCnt,
  output logic [CNT_W-1:0] huntFailCnt
);
  localparam int TW = $clog2(RST_CYCLES > HUNT_CYCLES ? RST_CYCLES : HUNT_CYCLES);
  localparam logic [TW-1:0] RST_LD  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] HUNT_LD = TW'(HUNT_CYCLES - 1);
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0] width_q, width_d;
  logic auto_q, auto_d;
  logic cfg_fixed, tmo;
  assign cfg_fixed = cfgWidth == W1 || cfgWidth == W2 || cfgWidth == W4;
  assign tmo = timer_q == '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      width_q <= W4;
      auto_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      width_q <= width_d;
      auto_q  <= auto_d;
    end
  end
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    width_d = width_q;
    auto_d  = auto_q;
    if (!enable) state_d = IDLE;
    else if (cfgStb) begin
      auto_d  = !cfg_fixed;
      width_d = cfg_fixed ? cfgWidth : W4;
      state_d = RESET;
      timer_d = RST_LD;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RESET;
          timer_d = RST_LD;
        end
        RESET: begin
          state_d = tmo ? HUNT : RESET;
          timer_d = tmo ? HUNT_LD : timer_q - 1'b1;
        end
        HUNT: begin
          state_d = sync ? LOCKED : tmo ? NEXT : HUNT;
          timer_d = tmo ? timer_q : timer_q - 1'b1;
        end
        LOCKED: begin
          state_d = sync ? LOCKED : RESET;
          timer_d = sync ? timer_q : RST_LD;
        end
        NEXT: begin
          width_d = auto_q ? next_width(width_q) : width_q;
          state_d = RESET;
          timer_d = RST_LD;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // NEXT keeps the stage in reset so the width step lands while ifRst is high
  assign ifRst  = state_q != HUNT && state_q != LOCKED;
  assign locked = state_q == LOCKED;
  assign width  = width_q;
  assign state  = state_q;
`ifdef TRACE_IF_CTRL_STATS_EN
  logic inc_loss, inc_fail;
  assign inc_loss = enable && !cfgStb && state_q == LOCKED && !sync;
  assign inc_fail = enable && !cfgStb && state_q == HUNT && !sync && tmo;
  trace_sat_counter #(.W(CNT_W)) u_loss (.clk(clk), .rst(rst), .inc_i(inc_loss), .cnt_o(lossCnt));
  trace_sat_counter #(.W(CNT_W)) u_fail (.clk(clk), .rst(rst), .inc_i(inc_fail), .cnt_o(huntFailCnt));
`else
  assign lossCnt     = '0;
  assign huntFailCnt = '0;
`endif
endmodule

// File: tb/tb_trace_if_ctrl.sv
// tb_trace_if_ctrl: scoreboard bench for trace_if_ctrl with directed vectors
module tb_trace_if_ctrl;
  import trace_pkg::*;
  localparam int RSTC = 4, HUNTC = 8, CW = 2;
`ifdef TRACE_IF_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, cfgStb = 1'b0, sync = 1'b0;
  logic [2:0] cfgWidth = 3'd0;
  logic [2:0] width, state;
  logic ifRst, locked;
  logic [CW-1:0] lossCnt, huntFailCnt;
  typedef struct {
    string nm;
    int cyc;
    logic [2:0] st, w;
    logic ir, lk;
    logic [CW-1:0] lc, hf;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, checks = 0, failures = 0, lc_e = 0, hf_e = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  trace_if_ctrl #(.RST_CYCLES(RSTC), .HUNT_CYCLES(HUNTC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .cfgWidth(cfgWidth), .cfgStb(cfgStb), .sync(sync),
    .width(width), .ifRst(ifRst), .locked(locked), .state(state),
    .lossCnt(lossCnt), .huntFailCnt(huntFailCnt)
  );
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  function automatic logic [CW-1:0] cv(input int v);
    return STATS ? CW'(v > 3 ? 3 : v) : '0;
  endfunction
  task automatic exp(input string nm, input state_t s, input logic [2:0] w, input logic ir, input logic lk);
    exp_t e;
    e.nm = nm; e.cyc = cyc; e.st = s; e.w = w; e.ir = ir; e.lk = lk;
    e.lc = cv(lc_e); e.hf = cv(hf_e);
    sb.push_back(e);
  endtask
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if ({state, width, ifRst, locked, lossCnt, huntFailCnt} !== {e.st, e.w, e.ir, e.lk, e.lc, e.hf}) begin
          failures++;
          $display("FAIL %s: got st=%0d w=%0d ifRst=%b locked=%b loss=%0d hfail=%0d, want st=%0d w=%0d ifRst=%b locked=%b loss=%0d hfail=%0d",
                   e.nm, state, width, ifRst, locked, lossCnt, huntFailCnt, e.st, e.w, e.ir, e.lk, e.lc, e.hf);
        end
      end
    end
  end
  initial begin
    int ws [4] = '{4, 2, 1, 4};
    tick(3);
    exp("reset", IDLE, 3'd4, 1'b1, 1'b0);
    rst = 1'b1; enable = 1'b1;
    tick();
    exp("rst_first", RESET, 3'd4, 1'b1, 1'b0);
    tick(3);
    exp("rst_last", RESET, 3'd4, 1'b1, 1'b0);
    tick();
    exp("hunt_entry", HUNT, 3'd4, 1'b0, 1'b0);
    tick(4);
    exp("hunt_wait", HUNT, 3'd4, 1'b0, 1'b0);
    sync = 1'b1;
    tick();
    exp("auto_lock", LOCKED, 3'd4, 1'b0, 1'b1);
    tick(2);
    sync = 1'b0;
    tick();
    lc_e++;
    exp("loss_reset", RESET, 3'd4, 1'b1, 1'b0);
    sync = 1'b1;
    tick(4);
    exp("loss_hunt", HUNT, 3'd4, 1'b0, 1'b0);
    tick();
    exp("relock", LOCKED, 3'd4, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      sync = 1'b0;
      tick();
      lc_e++;
      exp("sat_loss", RESET, 3'd4, 1'b1, 1'b0);
      sync = 1'b1;
      tick(5);
      exp("sat_relock", LOCKED, 3'd4, 1'b0, 1'b1);
    end
    sync = 1'b0;
    tick();
    lc_e++;
    exp("walk_reset", RESET, 3'd4, 1'b1, 1'b0);
    tick(4);
    exp("walk_hunt0", HUNT, 3'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(7);
      exp("walk_hunt_end", HUNT, 3'(ws[i]), 1'b0, 1'b0);
      tick();
      hf_e++;
      exp("walk_next", NEXT, 3'(ws[i]), 1'b1, 1'b0);
      tick();
      exp("walk_step", RESET, 3'(ws[i+1]), 1'b1, 1'b0);
      tick(4);
      exp("walk_hunt", HUNT, 3'(ws[i+1]), 1'b0, 1'b0);
    end
    cfgWidth = 3'd2; cfgStb = 1'b1;
    tick();
    exp("fix_stb", RESET, 3'd2, 1'b1, 1'b0);
    cfgStb = 1'b0;
    tick(4);
    exp("fix_hunt", HUNT, 3'd2, 1'b0, 1'b0);
    tick(8);
    hf_e++;
    exp("fix_next", NEXT, 3'd2, 1'b1, 1'b0);
    tick();
    exp("fix_hold", RESET, 3'd2, 1'b1, 1'b0);
    tick(4);
    sync = 1'b1;
    tick();
    exp("fix_lock", LOCKED, 3'd2, 1'b0, 1'b1);
    sync = 1'b0;
    tick();
    lc_e++;
    tick(4);
    exp("prec_hunt", HUNT, 3'd2, 1'b0, 1'b0);
    sync = 1'b1; cfgStb = 1'b1; cfgWidth = 3'd3;
    tick();
    exp("prec_stb", RESET, 3'd4, 1'b1, 1'b0);
    cfgStb = 1'b0;
    tick(5);
    exp("prec_lock", LOCKED, 3'd4, 1'b0, 1'b1);
    cfgWidth = 3'd1; cfgStb = 1'b1;
    tick();
    exp("w1_stb", RESET, 3'd1, 1'b1, 1'b0);
    cfgStb = 1'b0;
    tick(5);
    exp("w1_lock", LOCKED, 3'd1, 1'b0, 1'b1);
    enable = 1'b0;
    tick();
    exp("dis_idle", IDLE, 3'd1, 1'b1, 1'b0);
    tick();
    exp("dis_hold", IDLE, 3'd1, 1'b1, 1'b0);
    rst = 1'b0;
    tick();
    lc_e = 0; hf_e = 0;
    exp("mid_rst", IDLE, 3'd4, 1'b1, 1'b0);
    rst = 1'b1; enable = 1'b1;
    tick();
    exp("restart", RESET, 3'd4, 1'b1, 1'b0);
    tick(2);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trace_if_ctrl.md
Name: trace_if_ctrl

Overview:
- Sequencer for the trace pin front end: owns its bus width and its reset, and supervises its sync indication.
- Finds a working width by cycling candidates 4 -> 2 -> 1 (auto mode), or holds a host-fixed width, and re-hunts whenever sync is lost.
- Sits between the host config registers and the trace input stage; everything upstream sees only `locked` and the chosen width.

Parameters:
- RST_CYCLES, 16: cycles `ifRst` is held high on each (re)start; must be >=1.
- HUNT_CYCLES, 2_000_000: cycles allowed in HUNT for sync before giving up on the current width; must be >=2.
- CNT_W, 8: width of the statistics counters.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `enable`  in  1  1 = run the controller; 0 = hold the front end in reset.
- `cfgWidth`  in  3  requested width: 0 = auto, 1/2/4 = fixed; other values are treated as auto.
- `cfgStb`  in  1  one-cycle strobe; samples `cfgWidth` and restarts the sequence.
- `sync`  in  1  sync indication from the trace input stage, already in the `clk` domain.
- `width`  out  3  bus width driven to the trace input stage.
- `ifRst`  out  1  active-high reset to the trace input stage.
- `locked`  out  1  1 while in LOCKED.
- `state`  out  3  FSM state encoding, for debug.
- `lossCnt`  out  CNT_W  saturating count of LOCKED -> sync-loss events.
- `huntFailCnt`  out  CNT_W  saturating count of HUNT timeouts.

Behaviour:
- Reset values (`rst`=0): state=IDLE, `width`=4, `ifRst`=1, `locked`=0, counters=0, mode=auto, internal timer=0.
- States and encoding: IDLE=0, RESET=1, HUNT=2, LOCKED=3, NEXT=4.
- IDLE: `ifRst`=1. When `enable`=1 -> RESET, timer loaded with RST_CYCLES-1.
- RESET: `ifRst`=1. Timer decrements; at timer==0 -> HUNT, timer loaded with HUNT_CYCLES-1.
- HUNT: `ifRst`=0.
  - `sync`=1 -> LOCKED on the next cycle.
  - Else, at timer==0: huntFailCnt++ and -> NEXT.
- LOCKED: `locked`=1, `ifRst`=0. `sync`=0 -> lossCnt++ and -> RESET with the same width; `locked` drops the same cycle the state leaves LOCKED.
- NEXT, one cycle, then -> RESET:
  - auto mode: `width` steps 4 -> 2 -> 1 -> 4 (wraps).
  - fixed mode: `width` unchanged.
- `width` changes only in NEXT or on `cfgStb`. It is never changed while `ifRst`=0.
- `cfgStb` (any state, `enable`=1):
  - latch mode (fixed if `cfgWidth` is 1, 2 or 4; else auto);
  - set `width` to `cfgWidth` if fixed, else 4;
  - -> RESET with timer reloaded.
- `cfgStb` in the same cycle as a `sync` edge: the strobe wins.
- `enable`=0 in any state -> IDLE next cycle. Mode and counters are retained.
- `rst` asserted mid-operation: full return to reset values next edge, counters cleared.
- Counters saturate at all-ones and never wrap.
- Latencies:
  - `sync` rise in HUNT to `locked`=1: 1 cycle.
  - `sync` fall in LOCKED to `ifRst`=1: 1 cycle.
- Timer width is $clog2(max(RST_CYCLES, HUNT_CYCLES)); it is never compared beyond its loaded value.

Optional Feature:
- Macro: TRACE_IF_CTRL_STATS_EN.
- Defined: `lossCnt` and `huntFailCnt` are implemented as above.
- Undefined: both outputs are tied to 0 and no counter flops are inferred. FSM behaviour is otherwise identical.

Decomposition:
- Shared package (trace_pkg):
  - state enumeration constants (IDLE..NEXT);
  - width constants W1=1, W2=2, W4=4;
  - function next_width(w): 4 -> 2, 2 -> 1, 1 -> 4.
- One natural sub-module: trace_sat_counter, a CNT_W saturating incrementer with synchronous active-low clear, instantiated twice under the macro.

Test Plan:
- Reset and auto-lock: `rst`=0 for 3 cycles, then `enable`=1, `sync` rises 5 cycles into HUNT -> `ifRst` high for exactly RST_CYCLES cycles, `width`=4, `locked`=1 one cycle after `sync`.
- Auto width walk: HUNT_CYCLES=8, `sync` held 0 -> `width` sequence 4, 2, 1, 4 across successive HUNT windows; huntFailCnt=3 after three timeouts; `ifRst` high around every width change.
- Fixed width: `cfgWidth`=2 with `cfgStb`, `sync` held 0 -> `width` stays 2 across timeouts; then `sync`=1 -> `locked`=1 with `width`=2.
- Sync loss: in LOCKED drop `sync` for 1 cycle -> lossCnt=1, `locked`=0 and `ifRst`=1 next cycle, `width` unchanged; re-raise `sync` after RESET -> re-lock.
- Saturation and precedence: CNT_W=2, force 5 losses -> lossCnt=3; `cfgStb` coincident with `sync` rise in HUNT -> state=RESET, not LOCKED.
- Disable and reset mid-lock: `enable`=0 while LOCKED -> IDLE, `ifRst`=1, counters kept; `rst`=0 -> counters 0, `width`=4. Repeat with TRACE_IF_CTRL_STATS_EN undefined -> counters read 0 throughout.
